// File: rtl/axis_pulse_analyzer.sv
// AXI4-Stream pulse analyzer: encodes each sample with the idle-cycle count that followed it.
// Optional `flush` input (emit pending sample early) enabled by AXIS_PULSE_ANALYZER_FLUSH_EN.
module axis_pulse_analyzer (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
`ifdef AXIS_PULSE_ANALYZER_FLUSH_EN
  ,
  input  logic        flush
`endif
);
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned COUNT_W  = 32;
  localparam int unsigned RSVD_W   = 16;

  typedef struct packed {
    logic [COUNT_W-1:0]  idle;
    logic [RSVD_W-1:0]   rsvd;
    logic [SAMPLE_W-1:0] sample;
  } desc_t;

  logic [SAMPLE_W-1:0] held, held_nxt;
  logic                pending, pending_nxt;
  logic [COUNT_W-1:0]  idle_cnt, cnt_nxt;
  desc_t               out_q, out_nxt;
  logic                valid_nxt;
  logic                accept, flush_take, emit;
  desc_t               desc;

  // Output slot is free when empty or being drained this cycle.
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;

`ifdef AXIS_PULSE_ANALYZER_FLUSH_EN
  assign flush_take = flush & pending & ~accept & s_axis_tready;
`else
  assign flush_take = 1'b0;
`endif

  assign emit = (accept & pending) | flush_take;
  assign desc = '{idle: idle_cnt, rsvd: RSVD_W'(0), sample: held};

  assign m_axis_tdata = out_q;

  // Next-state for sample hold, idle counter and output slot.
  always_comb begin
    held_nxt    = held;
    pending_nxt = pending;
    cnt_nxt     = idle_cnt;
    out_nxt     = out_q;
    valid_nxt   = m_axis_tvalid;

    if (m_axis_tready) valid_nxt = 1'b0;
    if (emit) begin
      out_nxt   = desc;
      valid_nxt = 1'b1;
    end

    if (accept) begin
      held_nxt    = s_axis_tdata;
      pending_nxt = 1'b1;
      cnt_nxt     = '0;
    end else if (flush_take) begin
      pending_nxt = 1'b0;
      cnt_nxt     = '0;
    end else if (pending && (idle_cnt != '1)) begin
      cnt_nxt = idle_cnt + COUNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      held          <= '0;
      pending       <= 1'b0;
      idle_cnt      <= '0;
      out_q         <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      held          <= held_nxt;
      pending       <= pending_nxt;
      idle_cnt      <= cnt_nxt;
      out_q         <= out_nxt;
      m_axis_tvalid <= valid_nxt;
    end
  end
endmodule
